// File: rtl/radius_burst_feeder.sv
`default_nettype none
// ============================================================================
// Module   : radius_burst_feeder
// Purpose  : Buffers one polygon of radius samples, replays it to the surface
//            calculator as a gap-free burst, then returns the captured surface.
// Revision : 1.0 - initial release
// ============================================================================
module radius_burst_feeder #(
  parameter int N_SAMPLES    = 64,
  parameter int DW           = 16,
  parameter int SW           = 32,
  parameter int DRAIN_CYCLES = 8,
  parameter int CLOSE_LOOP   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          abort,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_radius,
  output logic          calc_en,
  output logic [DW-1:0] calc_radius,
  input  logic [SW-1:0] calc_surf,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [SW-1:0] m_surf,
  output logic          busy
);

  localparam int C_PTR_W     = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int C_BURST_LEN = N_SAMPLES + ((CLOSE_LOOP != 0) ? 1 : 0);
  localparam int C_BURST_W   = $clog2(C_BURST_LEN + 1);
  localparam int C_DRAIN_W   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [C_PTR_W-1:0]   C_LAST_PTR   = C_PTR_W'(N_SAMPLES - 1);
  localparam logic [C_BURST_W-1:0] C_BURST_END  = C_BURST_W'(C_BURST_LEN);
  localparam logic [C_DRAIN_W-1:0] C_DRAIN_LAST = C_DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t               r_state;
  logic [DW-1:0]        r_buf [N_SAMPLES];
  logic [C_PTR_W-1:0]   r_wr_ptr;
  logic [C_PTR_W-1:0]   r_rd_ptr;
  logic [C_BURST_W-1:0] r_burst_cnt;
  logic [C_DRAIN_W-1:0] r_drain_cnt;
  logic                 r_calc_en;
  logic [DW-1:0]        r_calc_radius;
  logic                 r_m_valid;
  logic [SW-1:0]        r_m_surf;

  logic w_load_hs;

  assign w_load_hs   = (r_state == LOAD) && s_valid;
  assign s_ready     = (r_state == LOAD);
  assign busy        = (r_state != LOAD);
  assign calc_en     = r_calc_en;
  assign calc_radius = r_calc_radius;
  assign m_valid     = r_m_valid;
  assign m_surf      = r_m_surf;

  // Sample storage carries no reset; a sample seen together with abort is dropped.
  always_ff @(posedge clk) begin
    if (w_load_hs && !abort) begin
      r_buf[r_wr_ptr] <= s_radius;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= LOAD;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_burst_cnt   <= '0;
      r_drain_cnt   <= '0;
      r_calc_en     <= 1'b0;
      r_calc_radius <= '0;
      r_m_valid     <= 1'b0;
      r_m_surf      <= '0;
    end else if (abort) begin
      r_state       <= LOAD;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_calc_en     <= 1'b0;
      r_calc_radius <= '0;
      r_m_valid     <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_load_hs) begin
            if (r_wr_ptr == C_LAST_PTR) begin
              // buf[0] was written on an earlier edge, so it is safe to launch it now.
              r_wr_ptr      <= '0;
              r_state       <= STREAM;
              r_calc_en     <= 1'b1;
              r_calc_radius <= r_buf[0];
              r_rd_ptr      <= C_PTR_W'(1);
              r_burst_cnt   <= C_BURST_W'(1);
            end else begin
              r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
          end
        end
        STREAM: begin
          if (r_burst_cnt == C_BURST_END) begin
            r_calc_en     <= 1'b0;
            r_calc_radius <= '0;
            r_drain_cnt   <= '0;
            r_state       <= DRAIN;
          end else begin
            r_calc_radius <= r_buf[r_rd_ptr];
            r_rd_ptr      <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + C_PTR_W'(1);
            r_burst_cnt   <= r_burst_cnt + C_BURST_W'(1);
          end
        end
        DRAIN: begin
          if (r_drain_cnt == C_DRAIN_LAST) begin
            r_m_surf  <= calc_surf;
            r_m_valid <= 1'b1;
            r_state   <= RESULT;
          end else begin
            r_drain_cnt <= r_drain_cnt + C_DRAIN_W'(1);
          end
        end
        RESULT: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_radius_burst_feeder.sv
`default_nettype none
// Randomized bench for radius_burst_feeder: a queue model of each polygon predicts
// the burst contents, drain latency and result handshake for two configurations.
module tb_radius_burst_feeder;

  localparam int N  = 64;
  localparam int DW = 16;
  localparam int SW = 32;
  localparam int D  = 8;
  localparam int NB = 8;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // configuration A: defaults (64 samples, closed loop)
  logic          abort = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
  logic          s_ready, calc_en, m_valid, busy;
  logic [DW-1:0] s_radius = '0, calc_radius;
  logic [SW-1:0] calc_surf = '0, m_surf;

  // configuration B: 8 samples, open loop, short drain
  logic          b_abort = 1'b0, b_s_valid = 1'b0, b_m_ready = 1'b1;
  logic          b_s_ready, b_calc_en, b_m_valid, b_busy;
  logic [DW-1:0] b_s_radius = '0, b_calc_radius;
  logic [SW-1:0] b_calc_surf = '0, b_m_surf;

  radius_burst_feeder dut_a (
    .clk(clk), .rst(rst), .abort(abort), .s_valid(s_valid), .s_ready(s_ready),
    .s_radius(s_radius), .calc_en(calc_en), .calc_radius(calc_radius),
    .calc_surf(calc_surf), .m_valid(m_valid), .m_ready(m_ready), .m_surf(m_surf),
    .busy(busy)
  );

  radius_burst_feeder #(
    .N_SAMPLES(NB), .DW(DW), .SW(SW), .DRAIN_CYCLES(DB), .CLOSE_LOOP(0)
  ) dut_b (
    .clk(clk), .rst(rst), .abort(b_abort), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .s_radius(b_s_radius), .calc_en(b_calc_en), .calc_radius(b_calc_radius),
    .calc_surf(b_calc_surf), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_surf(b_m_surf),
    .busy(b_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // burst monitors: every calc_en cycle is logged with its radius
  logic [DW-1:0] got_q[$], b_got_q[$];
  int en_runs = 0, last_en_cyc = 0, b_runs = 0, b_last_en = 0;
  logic prev_en = 1'b0, b_prev_en = 1'b0;

  always @(negedge clk) begin
    if (calc_en) begin
      got_q.push_back(calc_radius);
      last_en_cyc = cyc;
      if (!prev_en) en_runs++;
    end
    prev_en = calc_en;
    if (b_calc_en) begin
      b_got_q.push_back(b_calc_radius);
      b_last_en = cyc;
      if (!b_prev_en) b_runs++;
    end
    b_prev_en = b_calc_en;
  end

  logic [DW-1:0] model[$], b_model[$];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic new_poly();
    model.delete();
    got_q.delete();
    en_runs = 0;
  endtask

  // mode 0: ramp, continuous; mode 1: ramp, valid toggling; mode 2: random data and gaps
  task automatic load_a(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      logic [DW-1:0] v;
      v = (mode == 2) ? DW'($urandom) : DW'(model.size());
      if (mode == 1 && k > 0) begin s_valid = 1'b0; step(); end
      if (mode == 2) repeat ($urandom_range(0, 2)) begin s_valid = 1'b0; step(); end
      s_valid  = 1'b1;
      s_radius = v;
      model.push_back(v);
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic check_burst_a(input int hold, input logic [SW-1:0] surf);
    logic [DW-1:0] exp_q[$];
    int t;
    exp_q = model;
    exp_q.push_back(model[0]);
    m_ready = (hold == 0);
    check_eq("stream_en", {31'd0, calc_en}, 1);
    check_eq("stream_s_ready", {31'd0, s_ready}, 0);
    check_eq("stream_busy", {31'd0, busy}, 1);
    t = 0;
    while (!m_valid && t < 400) begin step(); t++; end
    check_eq("m_valid_seen", {31'd0, m_valid}, 1);
    check_eq("burst_len", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq("burst_data", {16'd0, got_q[i]}, {16'd0, exp_q[i]});
    check_eq("burst_runs", en_runs, 1);
    check_eq("drain_latency", cyc - last_en_cyc, D + 1);
    check_eq("m_surf", m_surf, surf);
    check_eq("result_s_ready", {31'd0, s_ready}, 0);
    if (hold > 0) begin
      repeat (hold) begin
        step();
        check_eq("hold_m_valid", {31'd0, m_valid}, 1);
        check_eq("hold_s_ready", {31'd0, s_ready}, 0);
      end
      check_eq("hold_m_surf", m_surf, surf);
      m_ready = 1'b1;
    end
    step();
    check_eq("ack_m_valid", {31'd0, m_valid}, 0);
    check_eq("ack_s_ready", {31'd0, s_ready}, 1);
    check_eq("ack_busy", {31'd0, busy}, 0);
    check_eq("ack_m_surf_kept", m_surf, surf);
  endtask

  initial begin
    logic [SW-1:0] surf, prev_surf;
    bit seen;
    int t;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_s_ready", {31'd0, s_ready}, 1);
    check_eq("rst_calc_en", {31'd0, calc_en}, 0);
    check_eq("rst_calc_radius", {16'd0, calc_radius}, 0);
    check_eq("rst_m_valid", {31'd0, m_valid}, 0);
    check_eq("rst_m_surf", m_surf, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    rst = 1'b1;
    step();

    // ramp, continuous valid
    calc_surf = 32'h1234_5678;
    new_poly(); load_a(N, 0); check_burst_a(0, 32'h1234_5678);

    // ramp, toggling valid
    surf = $urandom; calc_surf = surf;
    new_poly(); load_a(N, 1); check_burst_a(0, surf);

    // random data, result held back 20 cycles
    surf = $urandom; calc_surf = surf;
    new_poly(); load_a(N, 2); check_burst_a(20, surf);

    // abort at burst cycle 30
    prev_surf = m_surf;
    calc_surf = $urandom;
    new_poly(); load_a(N, 2);
    repeat (29) step();
    abort = 1'b1; step(); abort = 1'b0;
    check_eq("abort_calc_en", {31'd0, calc_en}, 0);
    check_eq("abort_calc_radius", {16'd0, calc_radius}, 0);
    check_eq("abort_s_ready", {31'd0, s_ready}, 1);
    seen = 1'b0;
    repeat (40) begin step(); if (m_valid) seen = 1'b1; end
    check_eq("abort_no_m_valid", {31'd0, seen}, 0);
    check_eq("abort_m_surf_kept", m_surf, prev_surf);
    surf = $urandom; calc_surf = surf;
    new_poly(); load_a(N, 2); check_burst_a(0, surf);

    // abort together with the last load sample
    new_poly(); load_a(N - 1, 2);
    s_valid = 1'b1; s_radius = DW'($urandom); abort = 1'b1;
    step();
    s_valid = 1'b0; abort = 1'b0;
    check_eq("abort_last_calc_en", {31'd0, calc_en}, 0);
    check_eq("abort_last_busy", {31'd0, busy}, 0);
    surf = $urandom; calc_surf = surf;
    new_poly(); load_a(N, 2); check_burst_a(0, surf);

    // reset mid-burst clears calc_en without waiting for a clock
    new_poly(); load_a(N, 2);
    repeat (9) step();
    #2 rst = 1'b0;
    #1;
    check_eq("rst_burst_calc_en", {31'd0, calc_en}, 0);
    check_eq("rst_burst_radius", {16'd0, calc_radius}, 0);
    check_eq("rst_burst_busy", {31'd0, busy}, 0);
    @(posedge clk); #1 rst = 1'b1;

    // reset while sample 40 is being offered
    new_poly(); load_a(40, 2);
    s_valid = 1'b1; s_radius = DW'($urandom);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_load_s_ready", {31'd0, s_ready}, 1);
    check_eq("rst_load_m_surf", m_surf, 0);
    check_eq("rst_load_busy", {31'd0, busy}, 0);
    @(posedge clk); #1 rst = 1'b1; s_valid = 1'b0;
    surf = $urandom; calc_surf = surf;
    new_poly(); load_a(N - 1, 2);
    step();
    check_eq("reload_63_calc_en", {31'd0, calc_en}, 0);
    check_eq("reload_63_busy", {31'd0, busy}, 0);
    load_a(1, 0);
    check_burst_a(0, surf);

    // open-loop configuration, no replay of sample 0
    for (int p = 0; p < 2; p++) begin
      b_model.delete(); b_got_q.delete(); b_runs = 0;
      surf = $urandom; b_calc_surf = surf;
      for (int k = 0; k < NB; k++) begin
        logic [DW-1:0] v;
        v = DW'($urandom);
        b_s_valid = 1'b1; b_s_radius = v; b_model.push_back(v);
        step();
      end
      b_s_valid = 1'b0;
      t = 0;
      while (!b_m_valid && t < 100) begin step(); t++; end
      check_eq("b_m_valid_seen", {31'd0, b_m_valid}, 1);
      check_eq("b_burst_len", b_got_q.size(), NB);
      for (int i = 0; i < NB && i < b_got_q.size(); i++)
        check_eq("b_burst_data", {16'd0, b_got_q[i]}, {16'd0, b_model[i]});
      check_eq("b_burst_runs", b_runs, 1);
      check_eq("b_drain_latency", cyc - b_last_en, DB + 1);
      check_eq("b_m_surf", b_m_surf, surf);
      step();
      check_eq("b_ack_m_valid", {31'd0, b_m_valid}, 0);
      check_eq("b_ack_s_ready", {31'd0, b_s_ready}, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
